// File: rtl/rptr_empty_fwft.sv
// Read-side controller of the async FIFO: wptr synchronizer, binary/Gray read pointer,
// empty / almost-empty / occupancy flags and a first-word-fall-through output register.
module rptr_empty_fwft #(
    parameter int ADDRSIZE    = 8,
    parameter int DATASIZE    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [DATASIZE-1:0] mem_rdata,
    input  logic                rready,
    input  logic [ADDRSIZE:0]   ae_thresh,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                rvalid,
    output logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE:0]   rcount,
    output logic                ralmost_empty
);

    logic [ADDRSIZE:0] rq_wptr [SYNC_STAGES];
    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] rdiff;
    logic              fetch;

    // The first stage is the only flop that samples the foreign-domain pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_wptr[i] <= '0;
            end
        end else begin
            rq_wptr[0] <= wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_wptr[i] <= rq_wptr[i-1];
            end
        end
    end

    assign rq2_wptr = rq_wptr[SYNC_STAGES-1];

    always_comb begin
        wbin_s = '0;
        wbin_s[ADDRSIZE] = rq2_wptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
        end
    end

    assign fetch     = ~rempty & (~rvalid | rready);
    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, fetch};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign rdiff     = wbin_s - rbinnext;
    assign raddr     = rbin[ADDRSIZE-1:0];

    // Flags are computed from the next pointer so they line up with the fetch that changes it.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            rcount        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            rempty        <= (rgraynext == rq2_wptr);
            rcount        <= rdiff;
            ralmost_empty <= (rdiff <= ae_thresh);
        end
    end

    // A fetch while the consumer takes the current word refills the register in the same cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (fetch) begin
            rvalid <= 1'b1;
            rdata  <= mem_rdata;
        end else if (rvalid & rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Scoreboard bench for rptr_empty_fwft: the bench plays the write side and the memory,
// pushes every written word into a queue and a monitor checks each accepted beat.
module tb_rptr_empty_fwft;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          rclk;
    logic          rrst_n;
    logic [AW:0]   wptr;
    logic [DW-1:0] mem_rdata;
    logic          rready;
    logic [AW:0]   ae_thresh;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [AW:0]   rcount;
    logic          ralmost_empty;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    logic [AW:0]   wbin;
    logic [DW-1:0] next_data;
    logic [AW:0]   prev_rptr;
    logic          gray_mon;
    int            checks;
    int            errors;
    int            pops;

    rptr_empty_fwft #(.ADDRSIZE(AW), .DATASIZE(DW), .SYNC_STAGES(2)) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .wptr(wptr),
        .mem_rdata(mem_rdata),
        .rready(rready),
        .ae_thresh(ae_thresh),
        .raddr(raddr),
        .rptr(rptr),
        .rempty(rempty),
        .rvalid(rvalid),
        .rdata(rdata),
        .rcount(rcount),
        .ralmost_empty(ralmost_empty)
    );

    assign mem_rdata = mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Writes n words; per-cycle mode advances wptr one word per clock, otherwise in one jump.
    task automatic applyStimulus(input int n, input bit per_cycle);
        for (int i = 0; i < n; i++) begin
            mem[wbin[AW-1:0]] = next_data;
            exp_q.push_back(next_data);
            next_data = next_data + 8'd1;
            wbin = wbin + 5'd1;
            if (per_cycle) begin
                wptr = bin2gray(wbin);
                if (i < n - 1) begin
                    @(posedge rclk); #1;
                end
            end
        end
        wptr = bin2gray(wbin);
    endtask

    task automatic waitDrain(input int budget, output int cycles);
        cycles = 0;
        forever begin
            @(posedge rclk); #1;
            cycles++;
            if (exp_q.size() == 0 && rvalid == 1'b0) break;
            if (cycles >= budget) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_timeout actual=%0d words left, required=0", exp_q.size());
                break;
            end
        end
    endtask

    always @(negedge rclk) begin
        if (rrst_n) begin
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_beat actual=%0h required=no beat", rdata);
                end else begin
                    checkOutput("rdata_beat", rdata, exp_q.pop_front());
                    pops++;
                end
            end
            if (gray_mon) begin
                checkOutput("rptr_gray_step", ($countones(rptr ^ prev_rptr) <= 1), 1);
                checkOutput("rcount_max", (rcount <= 5'd16), 1);
            end
        end
        prev_rptr = rptr;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int pops0;
        int expc;
        logic [DW-1:0] bp_base;
        logic [4:0] pat;

        checks = 0; errors = 0; pops = 0;
        gray_mon = 1'b0; prev_rptr = '0;
        rrst_n = 1'b0; rready = 1'b0; ae_thresh = 5'd3;
        wptr = '0; wbin = '0; next_data = 8'h40;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (2) @(posedge rclk);
        #1;
        checkOutput("reset_rempty", rempty, 1);
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_rcount", rcount, 0);
        checkOutput("reset_rptr", rptr, 0);
        checkOutput("reset_almost", ralmost_empty, 1);
        checkOutput("reset_rdata", rdata, 0);
        rrst_n = 1'b1;

        // Single word with the consumer stalled
        @(posedge rclk); #1;
        applyStimulus(1, 1'b0);
        @(posedge rclk); #1;
        checkOutput("single_e1_rempty", rempty, 1);
        @(posedge rclk); #1;
        checkOutput("single_e2_rempty", rempty, 1);
        @(posedge rclk); #1;
        checkOutput("single_e3_rempty", rempty, 0);
        checkOutput("single_e3_rvalid", rvalid, 0);
        checkOutput("single_e3_rcount", rcount, 1);
        @(posedge rclk); #1;
        checkOutput("single_e4_rvalid", rvalid, 1);
        checkOutput("single_e4_rdata", rdata, 8'h40);
        checkOutput("single_e4_rptr", rptr, 5'h01);
        checkOutput("single_e4_rempty", rempty, 1);
        repeat (3) @(posedge rclk);
        #1;
        checkOutput("single_hold_rdata", rdata, 8'h40);
        checkOutput("single_hold_rvalid", rvalid, 1);
        checkOutput("single_hold_rptr", rptr, 5'h01);
        rready = 1'b1;
        waitDrain(10, cyc);
        rready = 1'b0;

        // Reset in the middle of a stream drops the held word
        applyStimulus(3, 1'b1);
        repeat (5) @(posedge rclk);
        #3;
        rrst_n = 1'b0;
        #1;
        checkOutput("midreset_rempty", rempty, 1);
        checkOutput("midreset_rvalid", rvalid, 0);
        checkOutput("midreset_rcount", rcount, 0);
        checkOutput("midreset_rptr", rptr, 0);
        checkOutput("midreset_almost", ralmost_empty, 1);
        exp_q.delete();
        wbin = '0; wptr = '0;
        @(posedge rclk); #1;
        rrst_n = 1'b1;

        // Sixteen-word stream from a fresh pointer
        next_data = 8'h80;
        applyStimulus(16, 1'b1);
        checkOutput("stream_wptr", wptr, 5'h18);
        repeat (6) @(posedge rclk);
        #1;
        checkOutput("stream_pre_rvalid", rvalid, 1);
        checkOutput("stream_pre_rcount", rcount, 15);
        checkOutput("stream_pre_rptr", rptr, 5'h01);
        pops0 = pops;
        rready = 1'b1;
        waitDrain(40, cyc);
        checkOutput("stream_cycles", cyc, 16);
        checkOutput("stream_beats", pops - pops0, 16);
        checkOutput("stream_rempty", rempty, 1);
        checkOutput("stream_rptr", rptr, 5'h18);
        checkOutput("stream_raddr", raddr, 0);
        checkOutput("stream_rcount", rcount, 0);
        rready = 1'b0;

        // Backpressure pattern 1,0,0,1,1
        bp_base = next_data;
        applyStimulus(4, 1'b1);
        repeat (5) @(posedge rclk);
        #1;
        checkOutput("bp_first_rdata", rdata, bp_base);
        pat = 5'b11001;
        for (int i = 0; i < 5; i++) begin
            rready = pat[i];
            @(posedge rclk); #1;
            if (i == 2) checkOutput("bp_stall_rdata", rdata, bp_base + 8'd1);
        end
        rready = 1'b1;
        waitDrain(20, cyc);
        checkOutput("bp_queue_empty", exp_q.size(), 0);
        rready = 1'b0;

        // Almost-empty threshold stepping
        ae_thresh = 5'd3;
        applyStimulus(8, 1'b0);
        cyc = 0;
        do begin
            @(posedge rclk); #1;
            cyc++;
        end while (rempty && cyc < 10);
        checkOutput("ae_rempty_fall", rempty, 0);
        checkOutput("ae_rcount8", rcount, 8);
        checkOutput("ae_almost8", ralmost_empty, 0);
        @(posedge rclk); #1;
        checkOutput("ae_rvalid", rvalid, 1);
        checkOutput("ae_rcount7", rcount, 7);
        for (int k = 0; k < 8; k++) begin
            rready = 1'b1;
            @(posedge rclk); #1;
            rready = 1'b0;
            expc = (k < 7) ? 6 - k : 0;
            checkOutput("ae_rcount_step", rcount, expc);
            checkOutput("ae_almost_step", ralmost_empty, (expc <= 3));
        end
        checkOutput("ae_final_rvalid", rvalid, 0);

        // Wrap-around: 40 words in bursts of 5
        rready = 1'b1;
        gray_mon = 1'b1;
        pops0 = pops;
        for (int b = 0; b < 8; b++) begin
            applyStimulus(5, 1'b1);
            waitDrain(30, cyc);
        end
        gray_mon = 1'b0;
        rready = 1'b0;
        checkOutput("wrap_beats", pops - pops0, 40);
        checkOutput("wrap_rptr", rptr, bin2gray(wbin));
        checkOutput("wrap_rempty", rempty, 1);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge rclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
